camera_controller: RTL and testbench

CAMERA_CONTROLLER -- requirements
Module: camera_controller

---
 rtl/camera_controller.sv | 115 +++++++++++
 tb/tb_camera_controller.sv | 133 +++++++++++++
 2 files changed

// File: rtl/camera_controller.sv
// Vertical camera: scrolls one level at a time toward the player, advancing only on frame ticks.
// All outputs registered (one clock after the deciding edge); no backpressure, a started scroll always completes.
module camera_controller #(
  parameter int PHY_WIDTH    = 16,
  parameter int CAMERA_WIDTH = 6,
  parameter int LEVEL_HEIGHT = 480,
  parameter int SCROLL_STEP  = 4,
  parameter int MAX_LEVEL    = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    enable,
  input  logic [PHY_WIDTH-1:0]    player_y,
  output logic [CAMERA_WIDTH-1:0] camera_y,
  output logic [CAMERA_WIDTH-1:0] camera_offset,
  output logic                    scrolling,
  output logic                    level_changed
);

  typedef enum logic [1:0] {IDLE, SCROLL_UP, SCROLL_DOWN} state_t;

  localparam logic [PHY_WIDTH-1:0]    LH       = PHY_WIDTH'(LEVEL_HEIGHT);
  localparam logic [PHY_WIDTH:0]      LH_EXT   = (PHY_WIDTH+1)'(LEVEL_HEIGHT);
  localparam logic [CAMERA_WIDTH-1:0] STEP     = CAMERA_WIDTH'(SCROLL_STEP);
  localparam logic [CAMERA_WIDTH:0]   STEP_EXT = (CAMERA_WIDTH+1)'(SCROLL_STEP);
  localparam logic [CAMERA_WIDTH:0]   OFF_MAX  = {1'b0, {CAMERA_WIDTH{1'b1}}};
  localparam logic [CAMERA_WIDTH-1:0] TOP_LVL  = CAMERA_WIDTH'(MAX_LEVEL);

  state_t                  r_state, w_state_nxt;
  logic [CAMERA_WIDTH-1:0] r_camera_y, w_camera_y_nxt;
  logic [CAMERA_WIDTH-1:0] r_offset, w_offset_nxt;
  logic [PHY_WIDTH-1:0]    r_base_y, w_base_y_nxt;
  logic                    r_scrolling;
  logic                    r_level_changed, w_level_changed_nxt;

  logic [PHY_WIDTH:0]      w_base_top;
  logic                    w_up_req, w_down_req;
  logic [CAMERA_WIDTH:0]   w_off_inc;

  // Extra bit keeps base_y + LEVEL_HEIGHT from wrapping at the top of the world.
  assign w_base_top = {1'b0, r_base_y} + LH_EXT;
  assign w_up_req   = {1'b0, player_y} >= w_base_top;
  assign w_down_req = {1'b0, player_y} < {1'b0, r_base_y};
  assign w_off_inc  = {1'b0, r_offset} + STEP_EXT;

  always_comb begin
    w_state_nxt         = r_state;
    w_camera_y_nxt      = r_camera_y;
    w_offset_nxt        = r_offset;
    w_base_y_nxt        = r_base_y;
    w_level_changed_nxt = 1'b0;
    if (frame_tick) begin
      case (r_state)
        IDLE: begin
          if (enable && w_up_req && (r_camera_y < TOP_LVL)) begin
            w_state_nxt  = SCROLL_UP;
            w_offset_nxt = '0;
          end else if (enable && w_down_req && (r_camera_y != '0)) begin
            // Downward scroll switches level immediately and unwinds the offset.
            w_state_nxt    = SCROLL_DOWN;
            w_camera_y_nxt = r_camera_y - 1'b1;
            w_base_y_nxt   = r_base_y - LH;
            w_offset_nxt   = {CAMERA_WIDTH{1'b1}};
          end
        end
        SCROLL_UP: begin
          if (w_off_inc > OFF_MAX) begin
            w_state_nxt         = IDLE;
            w_camera_y_nxt      = r_camera_y + 1'b1;
            w_base_y_nxt        = r_base_y + LH;
            w_offset_nxt        = '0;
            w_level_changed_nxt = 1'b1;
          end else begin
            w_offset_nxt = w_off_inc[CAMERA_WIDTH-1:0];
          end
        end
        SCROLL_DOWN: begin
          if ({1'b0, r_offset} < STEP_EXT) begin
            w_state_nxt         = IDLE;
            w_offset_nxt        = '0;
            w_level_changed_nxt = 1'b1;
          end else begin
            w_offset_nxt = r_offset - STEP;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_camera_y      <= '0;
      r_offset        <= '0;
      r_base_y        <= '0;
      r_scrolling     <= 1'b0;
      r_level_changed <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_camera_y      <= w_camera_y_nxt;
      r_offset        <= w_offset_nxt;
      r_base_y        <= w_base_y_nxt;
      r_scrolling     <= (w_state_nxt != IDLE);
      r_level_changed <= w_level_changed_nxt;
    end
  end

  assign camera_y      = r_camera_y;
  assign camera_offset = r_offset;
  assign scrolling     = r_scrolling;
  assign level_changed = r_level_changed;

endmodule

// File: tb/tb_camera_controller.sv
// Directed bench for camera_controller: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_camera_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        enable;
  logic [15:0] player_y;
  logic [5:0]  camera_y;
  logic [5:0]  camera_offset;
  logic        scrolling;
  logic        level_changed;

  typedef struct {
    logic [5:0] cy;
    logic [5:0] off;
    logic       scr;
    logic       lc;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  camera_controller dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .enable        (enable),
    .player_y      (player_y),
    .camera_y      (camera_y),
    .camera_offset (camera_offset),
    .scrolling     (scrolling),
    .level_changed (level_changed)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per clock, checked half a cycle after the edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if ({camera_y, camera_offset, scrolling, level_changed} !== {e.cy, e.off, e.scr, e.lc}) begin
        bad++;
        $display("FAIL %s: got cy=%0d off=%0d scr=%0b lc=%0b want cy=%0d off=%0d scr=%0b lc=%0b",
                 e.tag, camera_y, camera_offset, scrolling, level_changed, e.cy, e.off, e.scr, e.lc);
      end
    end
  end

  task automatic cyc(input logic r, input logic ft, input logic en, input logic [15:0] py,
                     input logic [5:0] cy, input logic [5:0] off, input logic scr, input logic lc,
                     input string tag);
    exp_t x;
    rst = r; frame_tick = ft; enable = en; player_y = py;
    x.cy = cy; x.off = off; x.scr = scr; x.lc = lc; x.tag = tag;
    q.push_back(x);
    @(negedge clk);
  endtask

  // A tick cycle followed by a quiet cycle: state holds and level_changed clears.
  task automatic tick(input logic en, input logic [15:0] py, input logic [5:0] cy,
                      input logic [5:0] off, input logic scr, input logic lc, input string tag);
    cyc(1'b0, 1'b1, en, py, cy, off, scr, lc, tag);
    cyc(1'b0, 1'b0, en, py, cy, off, scr, 1'b0, {tag, "_hold"});
  endtask

  task automatic scroll_up(input logic [15:0] py, input int from, input string tag);
    for (int k = 1; k <= 16; k++)
      tick(1'b1, py, 6'(from), 6'(4 * (k - 1)), 1'b1, 1'b0, tag);
    tick(1'b1, py, 6'(from + 1), 6'd0, 1'b0, 1'b1, {tag, "_commit"});
  endtask

  task automatic scroll_down(input logic [15:0] py, input int from, input string tag);
    for (int k = 1; k <= 16; k++)
      tick(1'b1, py, 6'(from - 1), 6'(63 - 4 * (k - 1)), 1'b1, 1'b0, tag);
    tick(1'b1, py, 6'(from - 1), 6'd0, 1'b0, 1'b1, {tag, "_commit"});
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; enable = 1'b0; player_y = '0;
    cyc(1'b1, 1'b0, 1'b0, 16'd0, 6'd0, 6'd0, 1'b0, 1'b0, "reset");
    cyc(1'b1, 1'b1, 1'b1, 16'd480, 6'd0, 6'd0, 1'b0, 1'b0, "reset_tick");

    for (int i = 0; i < 5; i++)
      tick(1'b1, 16'd100, 6'd0, 6'd0, 1'b0, 1'b0, "idle_in_level");

    // Up scroll; enable and player_y wander mid-scroll and must be ignored.
    for (int k = 1; k <= 16; k++) begin
      if (k >= 5 && k <= 10)
        tick(1'b0, 16'd0, 6'd0, 6'(4 * (k - 1)), 1'b1, 1'b0, "up_ignore");
      else
        tick(1'b1, 16'd480, 6'd0, 6'(4 * (k - 1)), 1'b1, 1'b0, "up");
    end
    tick(1'b1, 16'd480, 6'd1, 6'd0, 1'b0, 1'b1, "up_commit");
    tick(1'b1, 16'd480, 6'd1, 6'd0, 1'b0, 1'b0, "lvl1_rest");

    scroll_down(16'd479, 1, "down");
    tick(1'b1, 16'd479, 6'd0, 6'd0, 1'b0, 1'b0, "lvl0_rest");

    scroll_up(16'd1500, 0, "jump1");
    scroll_up(16'd1500, 1, "jump2");
    scroll_up(16'd1500, 2, "jump3");
    tick(1'b1, 16'd1500, 6'd3, 6'd0, 1'b0, 1'b0, "jump_settled");

    for (int k = 1; k <= 9; k++)
      tick(1'b1, 16'd2000, 6'd3, 6'(4 * (k - 1)), 1'b1, 1'b0, "pre_rst");
    cyc(1'b1, 1'b1, 1'b1, 16'd2000, 6'd0, 6'd0, 1'b0, 1'b0, "rst_mid_scroll");
    cyc(1'b0, 1'b0, 1'b1, 16'd2000, 6'd0, 6'd0, 1'b0, 1'b0, "after_rst");

    for (int i = 0; i < 3; i++)
      tick(1'b0, 16'd480, 6'd0, 6'd0, 1'b0, 1'b0, "enable_off");

    for (int l = 0; l < 31; l++)
      scroll_up(16'hFFFF, l, "climb");
    for (int i = 0; i < 3; i++)
      tick(1'b1, 16'hFFFF, 6'd31, 6'd0, 1'b0, 1'b0, "max_level");

    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
